rtc_bus_arbiter: RTL and testbench
==================================

// Module: rtc_bus_arbiter
// PURPOSE
//  Owns the multiplexed 8-bit RTC bus (CS/AD/RD/WR strobes, shared DatAdd pins).
//  Arbitrates two requesters:
//   - rd: periodic time-register refresh feeding display memory.
//   - wr: user/button-driven register writes.
//  Sequences each granted access as a timed address phase then data phase.
//  Sits between the RTC control logic and the top-level tri-state pad for DatAdd.
// PARAMETERS
//  T_PHASE  4  cycles per bus sub-phase (legal 1..255); sets every strobe width
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-low reset
//  wr_req    in   1  write request; level, held high until wr_ack
//  wr_addr   in   8  RTC register address for write
//  wr_data   in   8  data to write
//  wr_ack    out  1  1-cycle pulse: write transaction complete
//  rd_req    in   1  read request; level, held high until rd_ack
//  rd_addr   in   8  RTC register address for read
//  rd_data   out  8  captured read data; valid from rd_ack, held until next read
//  rd_ack    out  1  1-cycle pulse: read complete
//  bus_cs_n  out  1  chip select, active-low
//  bus_ad_n  out  1  0 = address phase, 1 = data phase
//  bus_rd_n  out  1  read strobe, active-low
//  bus_wr_n  out  1  write strobe, active-low
//  bus_dout  out  8  value driven onto DatAdd when bus_oe = 1
//  bus_oe    out  1  pad output enable; 0 = DatAdd tri-stated
//  bus_din   in   8  DatAdd pad input
//  busy      out  1  1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async assert, any state): state = IDLE, all strobes = 1, bus_oe = 0,
//   bus_dout = 0, rd_data = 0, acks = 0, last_grant = RD, counter = 0.
//  All outputs are registered. phase_cnt is 8 bits; it counts 0..T_PHASE-1 in
//   each timed state and the state advances when phase_cnt == T_PHASE-1.
//  IDLE arbitration, evaluated each clk edge:
//   - Only one req high: grant it.
//   - Both high: grant the requester opposite to last_grant (round-robin);
//     the first tie after reset goes to wr.
//   - On grant: latch addr, data and op; update last_grant; enter A_SET next cycle.
//  Timed states, T_PHASE cycles each; strobes are 1 unless listed:
//   A_SET  cs_n=0 ad_n=0 oe=1 dout=addr
//   A_STB  as A_SET, plus wr_n=0
//   A_HLD  as A_SET
//   GAP    cs_n=1 ad_n=1 oe=0
//   D_SET  cs_n=0 ad_n=1; write: oe=1 dout=data; read: oe=0
//   D_STB  as D_SET, plus wr_n=0 (write) or rd_n=0 (read);
//          read: rd_data <= bus_din on the last D_STB cycle
//   D_HLD  as D_SET with no strobe
//   DONE   1 cycle: all strobes 1, oe=0, matching ack=1; then IDLE
//  Latency: grant edge k -> ack high during cycle k+1+7*T_PHASE.
//   Bus is busy for 7*T_PHASE+1 cycles.
//  Back-to-back: at least 1 IDLE cycle between transactions.
//   Requester drops req on the edge after ack.
//   A req still high in IDLE is treated as a new request.
//  req/addr/data changes after grant are ignored until IDLE.
//  Never: rd_n and wr_n low together; any strobe low while cs_n=1;
//   oe=1 during a read data phase.
// TESTING
//  T1 reset: reset=0 mid-D_STB -> same cycle all strobes 1, oe=0, busy=0;
//   after release, IDLE.
//  T2 write (T_PHASE=4): wr addr=0x21 data=0x59 -> ad_n=0/dout=0x21 for 12 cycles,
//   wr_n low 4 cycles in each phase, dout=0x59 in data phase; wr_ack at +29.
//  T3 read: rd addr=0x22, bus_din=0x37 during D_STB -> rd_n low 4 cycles, oe=0 in
//   data phase, rd_data=0x37 with rd_ack; rd_data held after.
//  T4 tie: wr_req and rd_req both high from reset -> order wr, rd, wr, rd;
//   exactly one ack per transaction.
//  T5 stability: change wr_addr/wr_data mid-transaction and drop wr_req early
//   -> latched values still driven; transaction completes with ack.
//  T6 assertions, every cycle all tests: never (rd_n=0 && wr_n=0); never (cs_n=1 &&
//   strobe low); never (oe=1 && rd_n=0); busy == (state != IDLE).

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin arbiter and phase sequencer for the multiplexed
// 8-bit RTC bus. Each granted access runs seven timed sub-phases (address set,
// strobe and hold, a turnaround gap, data set, strobe and hold), then a
// one-cycle DONE that pulses the matching ack.
module rtc_bus_arbiter #(
    parameter int unsigned T_PHASE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_req,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       rd_ack,
    output logic       bus_cs_n,
    output logic       bus_ad_n,
    output logic       bus_rd_n,
    output logic       bus_wr_n,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din,
    output logic       busy
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_LAST = CW'(T_PHASE - 1);

    typedef enum logic [3:0] {
        IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD, DONE
    } state_t;

    // Transaction latched at grant time
    typedef struct packed {
        logic          wr;
        logic [DW-1:0] addr;
        logic [DW-1:0] data;
    } xact_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    xact_t         xact_q, xact_d;
    logic          last_rd_q, last_rd_d;
    logic          phase_end;

    logic          cs_n_d, ad_n_d, rd_n_d, wr_n_d, oe_d, busy_d;
    logic          wr_ack_d, rd_ack_d;
    logic [DW-1:0] dout_d, rd_data_d;

    assign phase_end = (cnt_q == CNT_LAST);

    // Next-state, arbitration and next-output decode; outputs follow state_d
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        xact_d    = xact_q;
        last_rd_d = last_rd_q;
        rd_data_d = rd_data;
        cs_n_d    = 1'b1;
        ad_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        wr_n_d    = 1'b1;
        oe_d      = 1'b0;
        dout_d    = '0;
        wr_ack_d  = 1'b0;
        rd_ack_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Ties go to whichever side did not win last time
                if (wr_req && (!rd_req || last_rd_q)) begin
                    xact_d    = '{wr: 1'b1, addr: wr_addr, data: wr_data};
                    last_rd_d = 1'b0;
                    state_d   = A_SET;
                end else if (rd_req) begin
                    xact_d    = '{wr: 1'b0, addr: rd_addr, data: '0};
                    last_rd_d = 1'b1;
                    state_d   = A_SET;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                if (phase_end) begin
                    cnt_d = '0;
                    case (state_q)
                        A_SET:   state_d = A_STB;
                        A_STB:   state_d = A_HLD;
                        A_HLD:   state_d = GAP;
                        GAP:     state_d = D_SET;
                        D_SET:   state_d = D_STB;
                        D_STB:   state_d = D_HLD;
                        D_HLD:   state_d = DONE;
                        default: state_d = IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (state_q == D_STB && phase_end && !xact_q.wr) begin
                    rd_data_d = bus_din;
                end
            end
        endcase

        case (state_d)
            A_SET, A_HLD: begin
                cs_n_d = 1'b0;
                ad_n_d = 1'b0;
                oe_d   = 1'b1;
                dout_d = xact_d.addr;
            end
            A_STB: begin
                cs_n_d = 1'b0;
                ad_n_d = 1'b0;
                wr_n_d = 1'b0;
                oe_d   = 1'b1;
                dout_d = xact_d.addr;
            end
            D_SET, D_HLD: begin
                cs_n_d = 1'b0;
                oe_d   = xact_d.wr;
                dout_d = xact_d.wr ? xact_d.data : '0;
            end
            D_STB: begin
                cs_n_d = 1'b0;
                oe_d   = xact_d.wr;
                dout_d = xact_d.wr ? xact_d.data : '0;
                wr_n_d = !xact_d.wr;
                rd_n_d = xact_d.wr;
            end
            DONE: begin
                wr_ack_d = xact_d.wr;
                rd_ack_d = !xact_d.wr;
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, latched transaction and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            xact_q    <= '0;
            last_rd_q <= 1'b1;
            rd_data   <= '0;
            bus_cs_n  <= 1'b1;
            bus_ad_n  <= 1'b1;
            bus_rd_n  <= 1'b1;
            bus_wr_n  <= 1'b1;
            bus_oe    <= 1'b0;
            bus_dout  <= '0;
            wr_ack    <= 1'b0;
            rd_ack    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            xact_q    <= xact_d;
            last_rd_q <= last_rd_d;
            rd_data   <= rd_data_d;
            bus_cs_n  <= cs_n_d;
            bus_ad_n  <= ad_n_d;
            bus_rd_n  <= rd_n_d;
            bus_wr_n  <= wr_n_d;
            bus_oe    <= oe_d;
            bus_dout  <= dout_d;
            wr_ack    <= wr_ack_d;
            rd_ack    <= rd_ack_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: transaction-level reference model plus directed
// scenarios (reset, write, read, tie ordering, input stability) and random traffic.
module tb_rtc_bus_arbiter;

    localparam int TP = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req, rd_req;
    logic [7:0] wr_addr, wr_data, rd_addr, bus_din;
    logic       wr_ack, rd_ack;
    logic [7:0] rd_data, bus_dout;
    logic       bus_cs_n, bus_ad_n, bus_rd_n, bus_wr_n, bus_oe, busy;

    rtc_bus_arbiter #(.T_PHASE(TP)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ack   (rd_ack),
        .bus_cs_n (bus_cs_n),
        .bus_ad_n (bus_ad_n),
        .bus_rd_n (bus_rd_n),
        .bus_wr_n (bus_wr_n),
        .bus_dout (bus_dout),
        .bus_oe   (bus_oe),
        .bus_din  (bus_din),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ack_log[$];

    // Reference model: one transaction in flight, position = cycles since grant
    bit         m_busy;
    int         m_off;
    bit         m_wr;
    bit         m_last_rd;
    logic [7:0] m_addr, m_data, m_rdd;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_off = 0; m_wr = 0; m_last_rd = 1;
        m_addr = '0; m_data = '0; m_rdd = '0;
    endtask

    // Called at each rising edge with the inputs the DUT is sampling
    task automatic model_advance();
        bit gw, gr;
        if (!reset) begin
            model_reset();
        end else if (m_busy) begin
            if (m_off == 6*TP - 1 && !m_wr) m_rdd = bus_din;
            if (m_off == 7*TP) m_busy = 0;
            else m_off++;
        end else begin
            gw = wr_req && (!rd_req || m_last_rd);
            gr = rd_req && !gw;
            if (gw || gr) begin
                m_busy = 1; m_off = 0; m_wr = gw; m_last_rd = gr;
                m_addr = gw ? wr_addr : rd_addr;
                m_data = wr_data;
            end
        end
    endtask

    // Compare DUT outputs with what the model says this cycle must look like
    task automatic compare();
        int ph;
        logic e_cs, e_ad, e_rd, e_wr, e_oe, e_wack, e_rack;
        logic [7:0] e_dout;
        e_cs = 1; e_ad = 1; e_rd = 1; e_wr = 1; e_oe = 0; e_wack = 0; e_rack = 0;
        e_dout = '0;
        if (m_busy) begin
            ph = m_off / TP;
            case (ph)
                0, 1, 2: begin
                    e_cs = 0; e_ad = 0; e_oe = 1; e_dout = m_addr;
                    if (ph == 1) e_wr = 0;
                end
                4, 5, 6: begin
                    e_cs = 0; e_oe = m_wr; e_dout = m_data;
                    if (ph == 5) begin
                        if (m_wr) e_wr = 0;
                        else e_rd = 0;
                    end
                end
                7: begin
                    e_wack = m_wr; e_rack = !m_wr;
                end
                default: ;
            endcase
        end
        chk("cs_n", int'(bus_cs_n), int'(e_cs));
        chk("ad_n", int'(bus_ad_n), int'(e_ad));
        chk("rd_n", int'(bus_rd_n), int'(e_rd));
        chk("wr_n", int'(bus_wr_n), int'(e_wr));
        chk("oe", int'(bus_oe), int'(e_oe));
        if (e_oe) chk("dout", int'(bus_dout), int'(e_dout));
        chk("busy", int'(busy), int'(m_busy));
        chk("wr_ack", int'(wr_ack), int'(e_wack));
        chk("rd_ack", int'(rd_ack), int'(e_rack));
        chk("rd_data", int'(rd_data), int'(m_rdd));
        chk("inv_rd_wr_low", int'(!bus_rd_n && !bus_wr_n), 0);
        chk("inv_strobe_no_cs", int'(bus_cs_n && (!bus_rd_n || !bus_wr_n || !bus_ad_n)), 0);
        chk("inv_oe_during_rd", int'(bus_oe && !bus_rd_n), 0);
        if (wr_ack) ack_log.push_back(1);
        if (rd_ack) ack_log.push_back(0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_advance();
        @(negedge clk);
        compare();
    endtask

    task automatic wait_idle();
        int guard;
        wr_req = 0;
        rd_req = 0;
        guard = 0;
        do begin
            cyc();
            guard++;
        end while ((busy || m_busy) && guard < 200);
        chk("idle_timeout", int'(guard >= 200), 0);
        cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, c_ad, c_a21, c_wr, c_d59, c_rd, c_doe, got, bad_a, bad_d;
        int rd_at_ack;

        // Reset, with both requests already high for the tie test
        reset = 0; wr_req = 1; rd_req = 1;
        wr_addr = 8'h10; wr_data = 8'hA0; rd_addr = 8'h11; bus_din = 8'h00;
        model_reset();
        repeat (3) cyc();
        chk("rst_cs_n", int'(bus_cs_n), 1);
        chk("rst_wr_n", int'(bus_wr_n), 1);
        chk("rst_rd_n", int'(bus_rd_n), 1);
        chk("rst_oe", int'(bus_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rd_data", int'(rd_data), 0);

        // Tie from reset: wr first, then alternate; each side re-raises after its ack
        ack_log.delete();
        reset = 1;
        got = 0;
        for (int i = 0; i < 400 && got < 4; i++) begin
            cyc();
            wr_req = 1; rd_req = 1;
            if (wr_ack) begin wr_req = 0; got++; end
            if (rd_ack) begin rd_req = 0; got++; end
        end
        chk("tie_ack_count", ack_log.size(), 4);
        if (ack_log.size() >= 4) begin
            chk("tie_order0", ack_log[0], 1);
            chk("tie_order1", ack_log[1], 0);
            chk("tie_order2", ack_log[2], 1);
            chk("tie_order3", ack_log[3], 0);
        end
        wait_idle();

        // Directed write 0x59 -> reg 0x21
        wr_req = 1; wr_addr = 8'h21; wr_data = 8'h59;
        lat = 0; c_ad = 0; c_a21 = 0; c_wr = 0; c_d59 = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (!bus_ad_n) c_ad++;
            if (!bus_ad_n && bus_oe && bus_dout == 8'h21) c_a21++;
            if (!bus_wr_n) c_wr++;
            if (bus_oe && bus_ad_n && bus_dout == 8'h59) c_d59++;
            if (wr_ack) begin lat = i; break; end
        end
        wr_req = 0;
        chk("wr_latency", lat, 29);
        chk("wr_addr_cycles", c_ad, 12);
        chk("wr_addr_value", c_a21, 12);
        chk("wr_strobe_cycles", c_wr, 8);
        chk("wr_data_value", c_d59, 12);
        wait_idle();

        // Directed read of reg 0x22, pad returns 0x37
        rd_req = 1; rd_addr = 8'h22; bus_din = 8'h37;
        lat = 0; c_rd = 0; c_doe = 0; rd_at_ack = -1;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (!bus_rd_n) c_rd++;
            if (bus_oe && bus_ad_n) c_doe++;
            if (rd_ack) begin lat = i; rd_at_ack = int'(rd_data); break; end
        end
        rd_req = 0;
        bus_din = 8'hC4;
        chk("rd_latency", lat, 29);
        chk("rd_strobe_cycles", c_rd, 4);
        chk("rd_data_oe", c_doe, 0);
        chk("rd_data_at_ack", rd_at_ack, 8'h37);
        wait_idle();
        chk("rd_data_held", int'(rd_data), 8'h37);

        // Inputs change and request drops mid-transaction
        wr_req = 1; wr_addr = 8'h44; wr_data = 8'h9E;
        got = 0; bad_a = 0; bad_d = 0;
        for (int i = 1; i <= 100; i++) begin
            cyc();
            if (i == 3) begin wr_req = 0; wr_addr = 8'hFF; wr_data = 8'h00; end
            if (bus_oe && !bus_ad_n && bus_dout != 8'h44) bad_a++;
            if (bus_oe && bus_ad_n && bus_dout != 8'h9E) bad_d++;
            if (wr_ack) begin got = 1; break; end
        end
        chk("stab_ack", got, 1);
        chk("stab_addr", bad_a, 0);
        chk("stab_data", bad_d, 0);
        wait_idle();

        // Asynchronous reset in the middle of the read strobe
        rd_req = 1; rd_addr = 8'h5A; bus_din = 8'h66;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (m_busy && m_off == 5*TP + 1) break;
        end
        chk("pre_rst_rd_n", int'(bus_rd_n), 0);
        #1 reset = 0; rd_req = 0;
        #1;
        chk("arst_cs_n", int'(bus_cs_n), 1);
        chk("arst_rd_n", int'(bus_rd_n), 1);
        chk("arst_wr_n", int'(bus_wr_n), 1);
        chk("arst_ad_n", int'(bus_ad_n), 1);
        chk("arst_oe", int'(bus_oe), 0);
        chk("arst_busy", int'(busy), 0);
        model_reset();
        repeat (2) cyc();
        reset = 1;
        repeat (3) cyc();
        chk("post_rst_idle", int'(busy), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            bus_din = 8'($urandom);
            if (wr_ack) wr_req = 0;
            else if (!wr_req && $urandom_range(0, 3) == 0) begin
                wr_req = 1; wr_addr = 8'($urandom); wr_data = 8'($urandom);
            end else if (busy && $urandom_range(0, 15) == 0) begin
                wr_addr = 8'($urandom); wr_data = 8'($urandom);
                if ($urandom_range(0, 3) == 0) wr_req = 0;
            end
            if (rd_ack) rd_req = 0;
            else if (!rd_req && $urandom_range(0, 3) == 0) begin
                rd_req = 1; rd_addr = 8'($urandom);
            end else if (busy && $urandom_range(0, 15) == 0) begin
                rd_addr = 8'($urandom);
                if ($urandom_range(0, 3) == 0) rd_req = 0;
            end
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
